// File: rtl/ones_pattern_gen_if.sv
// Output stream interface of ones_pattern_gen.
//   out_valid : out_word/out_last/out_index are valid
//   out_ready : consumer accepts the current word this cycle
//   out_word  : current pattern
//   out_last  : current word is the final one of the sequence
//   out_index : zero-based ordinal of out_word within the sequence
// The master drives the stream and the slave consumes it.
interface ones_pattern_gen_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_last;
  logic [WIDTH-1:0] out_index;

  modport master (
    output out_valid,
    output out_word,
    output out_last,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    input  out_last,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: for a target ones-count k, streams every WIDTH-bit word
// whose popcount is k, in ascending numeric order, over a valid/ready stream.
// Ports:
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   start        : begin a sequence (sampled in IDLE only)
//   target_count : k, sampled together with an accepted start
//   busy         : high while a sequence is being emitted
//   done         : one-cycle pulse after the final word is accepted
//   err          : one-cycle pulse when start is given with k > WIDTH
//   bus          : output stream (valid/ready, word, last, index)
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  ones_pattern_gen_if.master bus
);

  localparam int TZ_W = $clog2(WIDTH);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] index_q;
  logic [CNT_W-1:0] k_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  // Lowest k bits set: first word of the sequence.
  function automatic logic [WIDTH-1:0] low_mask(input logic [CNT_W-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(k)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Highest k bits set: final word of the sequence.
  function automatic logic [WIDTH-1:0] top_mask(input logic [CNT_W-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= WIDTH - int'(k)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Gosper successor, computed one bit wider so the carry out of the final
  // word does not wrap into a bogus low value.
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   r_ext;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [TZ_W-1:0]  tz;
  logic [WIDTH-1:0] succ_d;
  logic             succ_last_d;
  logic             xfer;

  always_comb begin
    w_ext = {1'b0, word_q};
    c_ext = w_ext & (~w_ext + 1'b1);
    r_ext = w_ext + c_ext;
    x_ext = r_ext ^ w_ext;
    // Trailing-zero count replaces the divide by the lowest set bit.
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (word_q[i]) tz = TZ_W'(i);
    end
    nxt_ext = r_ext | ((x_ext >> 2) >> tz);
  end

  assign succ_d = nxt_ext[WIDTH-1:0];
  // A carry only appears when stepping past the final word, so it can never
  // mark a successor as last.
  assign succ_last_d = !nxt_ext[WIDTH] && (succ_d == top_mask(k_q));
  assign xfer = valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      index_q <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (int'(target_count) > WIDTH) begin
              err_q <= 1'b1;
            end else begin
              state_q <= EMIT;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              word_q  <= low_mask(target_count);
              index_q <= '0;
              k_q     <= target_count;
              // For k=0 and k=WIDTH the first word is also the final one.
              last_q  <= (low_mask(target_count) == top_mask(target_count));
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if (last_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              word_q  <= succ_d;
              index_q <= index_q + 1'b1;
              last_q  <= succ_last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_last  = last_q;
  assign bus.out_index = index_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] target_count;
  logic             busy;
  logic             done;
  logic             err;

  ones_pattern_gen_if #(.WIDTH(WIDTH)) bus ();

  ones_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .target_count (target_count),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               index;
    bit               last;
  } exp_t;

  typedef struct {
    int k;
    int len;
    int first;
    int last;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  int n_xfer;
  int first_w;
  int last_w;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int popcnt(input logic [WIDTH-1:0] v);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_valid"}, int'(bus.out_valid), 0);
    check({tag, "_word"},  int'(bus.out_word), 0);
    check({tag, "_last"},  int'(bus.out_last), 0);
    check({tag, "_index"}, int'(bus.out_index), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_err"},   int'(err), 0);
  endtask

  // Runs one sequence for target k. Expected words come from an exhaustive
  // ascending scan of all WIDTH-bit values.
  task automatic run_seq(input int k, input bit rnd_ready, input bit mid_start,
                         input bit chain, input int abort_after);
    exp_t e;
    int   exp_n;
    int   cycles;
    bit   finished;
    bit   ready;
    bit   prev_stall;
    int   prev_word;
    int   prev_index;
    int   prev_last;

    sb.delete();
    for (int v = 0; v < (1 << WIDTH); v++) begin
      if (popcnt(WIDTH'(v)) == k) begin
        e.word  = WIDTH'(v);
        e.index = sb.size();
        e.last  = 1'b0;
        sb.push_back(e);
      end
    end
    if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    exp_n = sb.size();
    n_xfer = 0;
    first_w = -1;
    last_w = -1;

    start = 1'b1;
    target_count = CNT_W'(k);
    step();
    start = 1'b0;

    if (k > WIDTH) begin
      check("err_pulse", int'(err), 1);
      check("err_busy", int'(busy), 0);
      check("err_valid", int'(bus.out_valid), 0);
      step();
      check("err_clear", int'(err), 0);
      check("err_done", int'(done), 0);
      check("err_busy2", int'(busy), 0);
      check("err_valid2", int'(bus.out_valid), 0);
      return;
    end

    check("start_busy", int'(busy), 1);
    check("start_index", int'(bus.out_index), 0);

    cycles = 0;
    finished = 1'b0;
    prev_stall = 1'b0;
    prev_word = 0;
    prev_index = 0;
    prev_last = 0;
    while (!finished && cycles < 4000) begin
      check("valid_held", int'(bus.out_valid), 1);
      check("no_early_done", int'(done), 0);
      check("popcount", popcnt(bus.out_word), k);
      if (prev_stall) begin
        check("stall_word", int'(bus.out_word), prev_word);
        check("stall_index", int'(bus.out_index), prev_index);
        check("stall_last", int'(bus.out_last), prev_last);
      end
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = ready;
      start = mid_start && n_xfer >= 3 && n_xfer < 6;
      target_count = mid_start ? CNT_W'(2) : CNT_W'(k);
      if (bus.out_valid && ready) begin
        if (sb.size() == 0) begin
          check("extra_word", int'(bus.out_word), -1);
        end else begin
          e = sb.pop_front();
          check("word", int'(bus.out_word), int'(e.word));
          check("index", int'(bus.out_index), e.index);
          check("last", int'(bus.out_last), int'(e.last));
        end
        if (n_xfer == 0) first_w = int'(bus.out_word);
        last_w = int'(bus.out_word);
        n_xfer++;
        if (bus.out_last) finished = 1'b1;
      end
      prev_stall = bus.out_valid && !ready;
      prev_word = int'(bus.out_word);
      prev_index = int'(bus.out_index);
      prev_last = int'(bus.out_last);
      step();
      cycles++;
      if (abort_after >= 0 && n_xfer == abort_after && !finished) begin
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("abort");
        step();
        check("abort_no_done", int'(done), 0);
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_valid", int'(bus.out_valid), 0);
        return;
      end
    end
    start = 1'b0;

    if (!finished) check("timeout", cycles, -1);
    check("seq_len", n_xfer, exp_n);
    check("sb_empty", sb.size(), 0);
    check("done_pulse", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_valid", int'(bus.out_valid), 0);
    check("done_last", int'(bus.out_last), 0);
    if (!rnd_ready) check("one_per_clk", cycles, exp_n);
    if (chain) return;
    step();
    check("done_clear", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{k: 0, len: 1,  first: 'h00, last: 'h00};
    tbl[1] = '{k: 1, len: 8,  first: 'h01, last: 'h80};
    tbl[2] = '{k: 2, len: 28, first: 'h03, last: 'hC0};
    tbl[3] = '{k: 3, len: 56, first: 'h07, last: 'hE0};
    tbl[4] = '{k: 4, len: 70, first: 'h0F, last: 'hF0};
    tbl[5] = '{k: 5, len: 56, first: 'h1F, last: 'hF8};
    tbl[6] = '{k: 6, len: 28, first: 'h3F, last: 'hFC};
    tbl[7] = '{k: 7, len: 8,  first: 'h7F, last: 'hFE};
    tbl[8] = '{k: 8, len: 1,  first: 'hFF, last: 'hFF};
    tbl[9] = '{k: 9, len: 0,  first: 0,    last: 0};

    rst = 1'b1;
    start = 1'b0;
    target_count = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Every legal and one illegal k with ready held high.
    for (int i = 0; i < 10; i++) begin
      run_seq(tbl[i].k, 1'b0, 1'b0, 1'b0, -1);
      if (tbl[i].len > 0) begin
        check("tbl_len", n_xfer, tbl[i].len);
        check("tbl_first", first_w, tbl[i].first);
        check("tbl_last", last_w, tbl[i].last);
      end
    end

    // k=1 under random backpressure.
    run_seq(1, 1'b1, 1'b0, 1'b0, -1);
    check("rnd_len", n_xfer, 8);
    check("rnd_first", first_w, 'h01);
    check("rnd_last", last_w, 'h80);

    // k=4 abandoned by reset after 10 transfers, then k=3 from scratch.
    run_seq(4, 1'b0, 1'b0, 1'b0, 10);
    check("abort_xfers", n_xfer, 10);
    run_seq(3, 1'b0, 1'b0, 1'b0, -1);
    check("k3_len", n_xfer, 56);
    check("k3_first", first_w, 'h07);
    check("k3_last", last_w, 'hE0);

    // k=5 with start pulsed mid-sequence, then k=7 started in the done cycle.
    run_seq(5, 1'b0, 1'b1, 1'b1, -1);
    check("k5_len", n_xfer, 56);
    run_seq(7, 1'b0, 1'b0, 1'b0, -1);
    check("k7_len", n_xfer, 8);
    check("k7_first", first_w, 'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Inverse of the team's 8-bit popcount block (`count_ones`).
- Given a target ones-count k, it streams every WIDTH-bit word whose popcount equals k, in strictly ascending numeric order.
- Output uses a valid/ready handshake.
- Used as a stimulus and pattern source for bit-counting logic, and as a self-checking companion to `count_ones`.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..16.
- CNT_W, 4, width of target_count; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- target_count  input  CNT_W  k, the required number of ones; sampled with start.
- busy  output  1  high while a sequence is in progress (EMIT state).
- out_valid  output  1  out_word is valid.
- out_ready  input  1  consumer accepts out_word this cycle.
- out_word  output  WIDTH  current pattern; popcount equals k.
- out_last  output  1  qualifies out_valid; current word is the final one of the sequence.
- out_index  output  WIDTH  zero-based ordinal of out_word within the sequence.
- done  output  1  one-cycle pulse after the final handshake.
- err  output  1  one-cycle pulse when start is given with target_count > WIDTH.

Behaviour:
- Reset: rst high at a clock edge clears state to IDLE and forces busy, out_valid, out_word, out_last, out_index, done and err to 0. This applies mid-sequence; the partial sequence is abandoned and no done pulse is issued.
- Handshake: a transfer occurs on a clock edge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_word, out_last and out_index hold stable.
  - out_valid never drops without a transfer, except on rst.
- States: IDLE and EMIT.
- IDLE, start=1, target_count <= WIDTH:
  - next cycle: state EMIT, busy=1, out_valid=1, out_index=0;
  - out_word = (1<<k)-1, so k=0 gives all zeros and k=WIDTH gives all ones.
- IDLE, start=1, target_count > WIDTH: next cycle err=1 for one cycle; state stays IDLE; busy and out_valid stay 0.
- start while in EMIT is ignored. target_count is only sampled with an accepted start.
- EMIT, transfer, current word not final:
  - out_word updates to the next larger WIDTH-bit value with the same popcount;
  - out_index increments by 1;
  - out_valid stays 1. With out_ready held high the block sustains one word per clock.
- Final word: the k ones occupy the top k bits, i.e. ((1<<k)-1)<<(WIDTH-k). For k=0 and k=WIDTH the first word is also the final word. out_last=1 whenever out_valid=1 and out_word is the final word.
- EMIT, transfer of the final word: next cycle state IDLE, busy=0, out_valid=0, out_last=0, done=1 for exactly one cycle. A start presented in that done cycle is accepted normally.
- Successor arithmetic (Gosper step):
  - c = w & -w; r = w + c; next = r | (((r ^ w) >> 2) >> log2(c)).
  - Intermediate values are WIDTH+1 bits wide, so r may carry out at the final word; that carry is never used as an output.
  - No divider: the division by c is a shift by the trailing-zero count of c, implemented as a priority encoder.
  - The successor may be computed combinationally from the registered word or precomputed; no added latency is permitted.
- Sequence length is C(WIDTH,k). For WIDTH=8, k=0..8 gives 1, 8, 28, 56, 70, 56, 28, 8, 1. The last out_index is C(WIDTH,k)-1.
- Between sequences out_word and out_index hold their last value. In IDLE both are don't-care for checking, except immediately after reset, when both are 0.

Test Plan:
- k=0, out_ready=1 → exactly one word 0x00 with out_last=1 and out_index=0; done pulses on the following cycle; busy falls on the same cycle as done.
- k=2, out_ready=1 → 28 consecutive valid cycles: 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11, …; last word 0xC0 with out_last=1 and out_index=27; every word is checked against `count_ones`, which must return 2.
- k=1 with out_ready toggled pseudo-randomly → sequence 0x01, 0x02, 0x04, …, 0x80 with no duplicates or skips; out_word is stable on every cycle where valid=1 and ready=0.
- k=8 → single word 0xFF with out_last=1, then done. k=9 → err pulse one cycle after start; busy, out_valid and done all stay 0.
- k=4, assert rst after 10 transfers → next cycle all outputs are 0 and no done pulse. Then start with k=3 → first word 0x07, last word 0xE0 after 56 transfers.
- start re-asserted during EMIT for k=5 → ignored; the sequence completes 56 words. A start with k=7 in the done cycle → first word 0x7F one cycle later.
